// File: rtl/tia_latch_sequencer_pkg.sv
// Shared types, reset constants and parameter legality checks for the TIA latch sequencer.
package tia_latch_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_OPEN   = 3'd2,
      ST_FOLLOW = 3'd3,
      ST_CLOSE  = 3'd4,
      ST_DONE   = 3'd5
   } seq_state_e;

   // Every latch group holds (latch=1) whenever it is not being written.
   localparam logic LATCH_RESET_BIT = 1'b1;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   function automatic bit cfg_legal(input int unsigned num_latch,
                                    input int unsigned addr_width,
                                    input int unsigned follow_cycles,
                                    input int unsigned dead_cycles);
      return (num_latch >= 1) && (addr_width < 32) &&
             ((32'd1 << addr_width) >= num_latch) &&
             (follow_cycles >= 1) && (dead_cycles >= 1);
   endfunction

endpackage

// File: rtl/tia_latch_sequencer_if.sv
// Write bus and latch-bank strobes of the TIA latch sequencer.
// rd_addr/rd_data exist only when TIA_LATCH_READBACK_EN is defined.
interface tia_latch_sequencer_if #(
   parameter int unsigned NUM_LATCH  = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 3
);
   logic                  wr_req;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_ready;
   logic                  wr_ack;
   logic                  wr_err;
   logic [DATA_WIDTH-1:0] latch_in;
   logic [NUM_LATCH-1:0]  follow;
   logic [NUM_LATCH-1:0]  latch;
`ifdef TIA_LATCH_READBACK_EN
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;

   modport master (output wr_req, wr_addr, wr_data, rd_addr,
                   input  wr_ready, wr_ack, wr_err, latch_in, follow, latch, rd_data);
   modport slave  (input  wr_req, wr_addr, wr_data, rd_addr,
                   output wr_ready, wr_ack, wr_err, latch_in, follow, latch, rd_data);
`else
   modport master (output wr_req, wr_addr, wr_data,
                   input  wr_ready, wr_ack, wr_err, latch_in, follow, latch);
   modport slave  (input  wr_req, wr_addr, wr_data,
                   output wr_ready, wr_ack, wr_err, latch_in, follow, latch);
`endif
endinterface

// File: rtl/tia_latch_sequencer_phase_timer.sv
// Loadable down-counter with zero flag; times the OPEN/FOLLOW/CLOSE phases.
module tia_phase_timer #(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic             zero_o
);
   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);
endmodule

// File: rtl/tia_latch_sequencer.sv
// Sequences writes into NUM_LATCH tia_l follow/latch cells with non-overlapping strobes.
// Define TIA_LATCH_READBACK_EN to add a shadow copy readable on rd_addr/rd_data.
module tia_latch_sequencer
   import tia_latch_seq_pkg::*;
#(
   parameter int unsigned NUM_LATCH     = 8,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned ADDR_WIDTH    = 3,
   parameter int unsigned FOLLOW_CYCLES = 2,
   parameter int unsigned DEAD_CYCLES   = 1
) (
   input logic                  clock,
   input logic                  reset_n,
   tia_latch_sequencer_if.slave bus
);
   localparam int unsigned PH_W = $clog2(max_u(FOLLOW_CYCLES, DEAD_CYCLES) + 1);
   localparam logic [PH_W-1:0] DEAD_LOAD   = PH_W'(DEAD_CYCLES - 1);
   localparam logic [PH_W-1:0] FOLLOW_LOAD = PH_W'(FOLLOW_CYCLES - 1);

   if (!cfg_legal(NUM_LATCH, ADDR_WIDTH, FOLLOW_CYCLES, DEAD_CYCLES)) begin : g_bad_cfg
      $error("tia_latch_sequencer: illegal parameter combination");
   end

   seq_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] latch_in_q, latch_in_d;
   logic                  ready_q, ready_d;
   logic                  ack_q, ack_d;
   logic                  werr_q, werr_d;
   logic [NUM_LATCH-1:0]  follow_q, follow_d;
   logic [NUM_LATCH-1:0]  latch_q, latch_d;
   logic [NUM_LATCH-1:0]  sel;
   logic                  accept, addr_valid;
   logic                  ph_load, ph_zero;
   logic [PH_W-1:0]       ph_val;

   tia_phase_timer #(.WIDTH(PH_W)) u_timer (
      .clock      (clock),
      .reset_n    (reset_n),
      .load_i     (ph_load),
      .load_val_i (ph_val),
      .zero_o     (ph_zero)
   );

   assign accept     = bus.wr_req & ready_q;
   assign addr_valid = (32'(bus.wr_addr) < NUM_LATCH);

   // Out-of-range addresses decode to no group, so the error path cannot touch a cell.
   always_comb begin
      sel = '0;
      for (int unsigned i = 0; i < NUM_LATCH; i++) begin
         if (32'(addr_q) == i) sel[i] = 1'b1;
      end
   end

   // Strobes are registered from the current state, so they trail the state by one cycle.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      err_d      = err_q;
      latch_in_d = latch_in_q;
      ready_d    = ready_q;
      ack_d      = 1'b0;
      werr_d     = 1'b0;
      follow_d   = '0;
      latch_d    = {NUM_LATCH{LATCH_RESET_BIT}};
      ph_load    = 1'b0;
      ph_val     = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               addr_d     = bus.wr_addr;
               latch_in_d = bus.wr_data;
               ready_d    = 1'b0;
               ph_load    = 1'b1;
               err_d      = !addr_valid;
               state_d    = addr_valid ? ST_SETUP : ST_DONE;
            end
         end
         ST_SETUP: begin
            ph_load = 1'b1;
            ph_val  = DEAD_LOAD;
            state_d = ST_OPEN;
         end
         ST_OPEN: begin
            latch_d = latch_d & ~sel;
            if (ph_zero) begin
               ph_load = 1'b1;
               ph_val  = FOLLOW_LOAD;
               state_d = ST_FOLLOW;
            end
         end
         ST_FOLLOW: begin
            latch_d  = latch_d & ~sel;
            follow_d = sel;
            if (ph_zero) begin
               ph_load = 1'b1;
               ph_val  = DEAD_LOAD;
               state_d = ST_CLOSE;
            end
         end
         ST_CLOSE: begin
            latch_d = latch_d & ~sel;
            if (ph_zero) begin
               ph_load = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            ack_d   = 1'b1;
            werr_d  = err_q;
            ready_d = 1'b1;
            ph_load = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         err_q      <= 1'b0;
         latch_in_q <= '0;
         ready_q    <= 1'b1;
         ack_q      <= 1'b0;
         werr_q     <= 1'b0;
         follow_q   <= '0;
         latch_q    <= {NUM_LATCH{LATCH_RESET_BIT}};
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         err_q      <= err_d;
         latch_in_q <= latch_in_d;
         ready_q    <= ready_d;
         ack_q      <= ack_d;
         werr_q     <= werr_d;
         follow_q   <= follow_d;
         latch_q    <= latch_d;
      end
   end

   assign bus.wr_ready = ready_q;
   assign bus.wr_ack   = ack_q;
   assign bus.wr_err   = werr_q;
   assign bus.latch_in = latch_in_q;
   assign bus.follow   = follow_q;
   assign bus.latch    = latch_q;

`ifdef TIA_LATCH_READBACK_EN
   logic [DATA_WIDTH-1:0] shadow_q [NUM_LATCH];
   logic [DATA_WIDTH-1:0] rd_data;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_LATCH; i++) shadow_q[i] <= '0;
      end else if (state_q == ST_DONE) begin
         for (int unsigned i = 0; i < NUM_LATCH; i++) begin
            if (sel[i]) shadow_q[i] <= latch_in_q;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int unsigned i = 0; i < NUM_LATCH; i++) begin
         if (32'(bus.rd_addr) == i) rd_data = shadow_q[i];
      end
   end

   assign bus.rd_data = rd_data;
`endif
endmodule

// File: tb/tb_tia_latch_sequencer.sv
// Self-checking bench for tia_latch_sequencer against a cycle-offset timing model.
module tb_tia_latch_sequencer;
   localparam int NL  = 8;
   localparam int NL6 = 6;
   localparam int DW  = 8;
   localparam int AW  = 3;
   localparam int FC  = 2;
   localparam int DC  = 1;
   localparam int LAT = 2 + 2*DC + FC;

   typedef struct packed {
      logic       ready;
      logic       ack;
      logic       err;
      logic [7:0] follow;
      logic [7:0] latch;
      logic [7:0] lin;
   } obs_t;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0, fails = 0;
   int   inv_checks = 0, inv_fails = 0;
   logic [7:0] ref_sh [NL];

   always #5 clock = ~clock;

   tia_latch_sequencer_if #(.NUM_LATCH(NL),  .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
   tia_latch_sequencer_if #(.NUM_LATCH(NL6), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus6 ();

   tia_latch_sequencer #(.NUM_LATCH(NL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                         .FOLLOW_CYCLES(FC), .DEAD_CYCLES(DC)) dut (
      .clock(clock), .reset_n(reset_n), .bus(bus));

   tia_latch_sequencer #(.NUM_LATCH(NL6), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                         .FOLLOW_CYCLES(FC), .DEAD_CYCLES(DC)) dut6 (
      .clock(clock), .reset_n(reset_n), .bus(bus6));

   // Expected outputs in the cycle starting k edges after the accept edge.
   function automatic obs_t model(input int k, input int a, input logic [7:0] d, input int nl);
      obs_t e;
      logic [8:0] full;
      bit valid;
      int lat;
      full  = (9'd1 << nl) - 9'd1;
      valid = (a < nl);
      lat   = valid ? LAT : 1;
      e.lin    = d;
      e.ready  = (k >= lat);
      e.ack    = (k == lat);
      e.err    = (k == lat) && !valid;
      e.follow = 8'h00;
      e.latch  = full[7:0];
      if (valid) begin
         if (k >= 2 && k < lat) e.latch[a] = 1'b0;
         if (k >= 2 + DC && k < 2 + DC + FC) e.follow[a] = 1'b1;
      end
      return e;
   endfunction

   always @(negedge clock) begin
      inv_checks++;
      if ((bus.follow & bus.latch) != '0 || $countones(bus.follow) > 1 ||
          (bus6.follow & bus6.latch) != '0 || $countones(bus6.follow) > 1) begin
         inv_fails++;
         $display("FAIL strobe_invariant t=%0t follow=%h latch=%h follow6=%h latch6=%h required disjoint, <=1 follow",
                  $time, bus.follow, bus.latch, bus6.follow, bus6.latch);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   // Caller must be just past a negedge with the DUT idle.
   task automatic run_write(input int a, input logic [7:0] d, input bit hold_req, input string tag);
      obs_t act, e;
      checks++;
      if (bus.wr_ready !== 1'b1) begin
         fails++;
         $display("FAIL %s_ready_before_accept got=%b required=1", tag, bus.wr_ready);
      end
      bus.wr_req  = 1'b1;
      bus.wr_addr = a[2:0];
      bus.wr_data = d;
      @(posedge clock);
      #1;
      if (!hold_req) bus.wr_req = 1'b0;
      for (int k = 0; k <= LAT; k++) begin
         @(negedge clock);
         e = model(k, a, d, NL);
         act.ready = bus.wr_ready; act.ack = bus.wr_ack; act.err = bus.wr_err;
         act.follow = bus.follow;  act.latch = bus.latch; act.lin = bus.latch_in;
         checks++;
         if (act !== e) begin
            fails++;
            $display("FAIL %s k=%0d got rdy=%b ack=%b err=%b fol=%h lat=%h lin=%h required rdy=%b ack=%b err=%b fol=%h lat=%h lin=%h",
                     tag, k, act.ready, act.ack, act.err, act.follow, act.latch, act.lin,
                     e.ready, e.ack, e.err, e.follow, e.latch, e.lin);
         end
      end
      ref_sh[a] = d;
   endtask

   task automatic test_reset();
      obs_t act;
      bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus6.wr_req = 1'b0; bus6.wr_addr = '0; bus6.wr_data = '0;
`ifdef TIA_LATCH_READBACK_EN
      bus.rd_addr = '0; bus6.rd_addr = '0;
`endif
      for (int i = 0; i < NL; i++) ref_sh[i] = 8'h00;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         act.ready = bus.wr_ready; act.ack = bus.wr_ack; act.err = bus.wr_err;
         act.follow = bus.follow;  act.latch = bus.latch; act.lin = bus.latch_in;
         checks++;
         if (act !== {1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00}) begin
            fails++;
            $display("FAIL reset_idle c=%0d got rdy=%b ack=%b err=%b fol=%h lat=%h lin=%h required 1 0 0 00 ff 00",
                     c, act.ready, act.ack, act.err, act.follow, act.latch, act.lin);
         end
      end
   endtask

   task automatic test_single_write();
      run_write(3, 8'hA5, 1'b0, "single_write");
   endtask

   task automatic test_invalid_addr();
      int addrs [3] = '{7, 6, 5};
      obs_t act, e;
      @(negedge clock);
      foreach (addrs[j]) begin
         int a = addrs[j];
         logic [7:0] d = 8'($urandom);
         int lat = (a < NL6) ? LAT : 1;
         bus6.wr_req = 1'b1; bus6.wr_addr = a[2:0]; bus6.wr_data = d;
         @(posedge clock);
         #1 bus6.wr_req = 1'b0;
         for (int k = 0; k <= lat; k++) begin
            @(negedge clock);
            e = model(k, a, d, NL6);
            act.ready = bus6.wr_ready; act.ack = bus6.wr_ack; act.err = bus6.wr_err;
            act.follow = {2'b00, bus6.follow}; act.latch = {2'b00, bus6.latch};
            act.lin = bus6.latch_in;
            checks++;
            if (act !== e) begin
               fails++;
               $display("FAIL invalid_addr a=%0d k=%0d got rdy=%b ack=%b err=%b fol=%h lat=%h lin=%h required rdy=%b ack=%b err=%b fol=%h lat=%h lin=%h",
                        a, k, act.ready, act.ack, act.err, act.follow, act.latch, act.lin,
                        e.ready, e.ack, e.err, e.follow, e.latch, e.lin);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clock);
      run_write(1, 8'h11, 1'b1, "b2b_first");
      run_write(2, 8'h22, 1'b0, "b2b_second");
   endtask

   task automatic test_reset_mid_follow();
      @(negedge clock);
      bus.wr_req = 1'b1; bus.wr_addr = 3'd5; bus.wr_data = 8'h77;
      @(posedge clock);
      #1 bus.wr_req = 1'b0;
      repeat (2 + DC + 1) @(negedge clock);
      checks++;
      if (bus.follow !== 8'h20 || bus.latch !== 8'hDF) begin
         fails++;
         $display("FAIL mid_follow_strobes got fol=%h lat=%h required fol=20 lat=df", bus.follow, bus.latch);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.wr_ready, bus.wr_ack, bus.wr_err, bus.follow, bus.latch, bus.latch_in} !==
          {1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00}) begin
         fails++;
         $display("FAIL async_reset got rdy=%b ack=%b err=%b fol=%h lat=%h lin=%h required 1 0 0 00 ff 00",
                  bus.wr_ready, bus.wr_ack, bus.wr_err, bus.follow, bus.latch, bus.latch_in);
      end
      for (int i = 0; i < NL; i++) ref_sh[i] = 8'h00;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      run_write(5, 8'h3C, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      for (int n = 0; n < 16; n++) begin
         int a = int'($urandom_range(0, NL - 1));
         logic [7:0] d = 8'($urandom);
         repeat ($urandom_range(1, 3)) @(negedge clock);
         run_write(a, d, 1'b0, "random");
      end
   endtask

`ifdef TIA_LATCH_READBACK_EN
   task automatic test_readback();
      @(negedge clock);
      run_write(4, 8'h5A, 1'b0, "readback_write");
      for (int i = 0; i < NL; i++) begin
         bus.rd_addr = 3'(i);
         #1;
         checks++;
         if (bus.rd_data !== ref_sh[i]) begin
            fails++;
            $display("FAIL readback addr=%0d got=%h required=%h", i, bus.rd_data, ref_sh[i]);
         end
      end
      bus6.rd_addr = 3'd7;
      #1;
      checks++;
      if (bus6.rd_data !== 8'h00) begin
         fails++;
         $display("FAIL readback_out_of_range got=%h required=00", bus6.rd_data);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_write();
      test_invalid_addr();
      test_back_to_back();
      test_reset_mid_follow();
      test_random();
`ifdef TIA_LATCH_READBACK_EN
      test_readback();
`endif
      repeat (2) @(negedge clock);
      checks += inv_checks;
      fails  += inv_fails;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
